// File: rtl/stripe_pkg.sv
// rtl/stripe_pkg.sv - shared types and constants for the stripe transmit controller
// Contents: one-hot FSM state encoding, active-lane-count codes, default fill byte,
//           and the cfg_lanes decode helper.
package stripe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ACTIVE = 3'b010,
        ST_PAD    = 3'b100
    } state_t;

    // Lane-count codes share the cfg_lanes encoding; 2'b11 folds onto LANES_4.
    typedef enum logic [1:0] {
        LANES_4 = 2'b00,
        LANES_1 = 2'b01,
        LANES_2 = 2'b10
    } lanes_t;

    localparam logic [7:0] DEF_PAD_BYTE = 8'hBC;

    function automatic lanes_t decode_lanes(input logic [1:0] cfg);
        case (cfg)
            2'b01:   decode_lanes = LANES_1;
            2'b10:   decode_lanes = LANES_2;
            default: decode_lanes = LANES_4;
        endcase
    endfunction

endpackage

// File: rtl/stripe_lane_ptr.sv
// rtl/stripe_lane_ptr.sv - round-robin lane pointer with modulo-N wrap
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   advance       step the pointer to next_ptr
//   clear         force the pointer to lane 0 (ignored when advance is high)
//   lanes         active lane count used for wrap and is_last
//   ptr           current lane index
//   next_ptr      value the pointer takes on advance
//   is_last       ptr is the last active lane (N-1)
module stripe_lane_ptr
    import stripe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       clear,
    input  lanes_t     lanes,
    output logic [1:0] ptr,
    output logic [1:0] next_ptr,
    output logic       is_last
);

    // Four lanes rely on natural 2-bit rollover; fewer lanes clear explicitly.
    always_comb begin
        next_ptr = ptr + 2'd1;
        is_last  = (ptr == 2'd3);
        case (lanes)
            LANES_1: begin
                next_ptr = 2'd0;
                is_last  = 1'b1;
            end
            LANES_2: begin
                next_ptr = (ptr == 2'd1) ? 2'd0 : ptr + 2'd1;
                is_last  = (ptr == 2'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (advance) begin
            ptr <= next_ptr;
        end else if (clear) begin
            ptr <= 2'd0;
        end
    end

endmodule

// File: rtl/stripe_tx_ctrl.sv
// rtl/stripe_tx_ctrl.sv - byte-to-lane sequencer with end-of-packet stripe padding
// Optional feature macro: STRIPE_CNT_EN (adds stripe_cnt counter output)
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   cfg_lanes             active lanes: 00/11 = 4, 01 = 1, 10 = 2
//   in_valid/in_data/in_last/in_ready   upstream byte stream
//   out_valid/out_data/out_lane/out_ready   registered stream toward the striper
//   stripe_done           pulse after a byte is accepted on lane N-1
//   busy                  high while a packet is in progress (ACTIVE or PAD)
//   stripe_cnt            completed-stripe counter (STRIPE_CNT_EN only)
module stripe_tx_ctrl
    import stripe_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = DEF_PAD_BYTE
`ifdef STRIPE_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cfg_lanes,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic [1:0]       out_lane,
    input  logic             out_ready,
    output logic             stripe_done,
`ifdef STRIPE_CNT_EN
    output logic [CNT_W-1:0] stripe_cnt,
`endif
    output logic             busy
);

    state_t     state;
    lanes_t     n_lat;
    lanes_t     cfg_n;
    lanes_t     lanes_eff;
    logic       load;
    logic       accept_data;
    logic       accept_pad;
    logic       accept;
    logic [1:0] ptr;
    logic [1:0] next_ptr;
    logic       is_last;

    assign cfg_n       = decode_lanes(cfg_lanes);
    assign load        = !out_valid || out_ready;
    assign in_ready    = (state != ST_PAD) && load;
    assign accept_data = in_valid && in_ready;
    assign accept_pad  = (state == ST_PAD) && load;
    assign accept      = accept_data || accept_pad;

    // The first byte of a packet must wrap on the live configuration, since
    // the latched count only updates on that same edge.
    assign lanes_eff = (state == ST_IDLE) ? cfg_n : n_lat;

    stripe_lane_ptr u_ptr (
        .clk      (clk),
        .reset    (reset),
        .advance  (accept),
        .clear    ((state == ST_IDLE) && !accept),
        .lanes    (lanes_eff),
        .ptr      (ptr),
        .next_ptr (next_ptr),
        .is_last  (is_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            n_lat       <= LANES_4;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            out_lane    <= 2'd0;
            stripe_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            stripe_done <= accept && is_last;

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= (state == ST_PAD) ? PAD_BYTE : in_data;
                out_lane  <= ptr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept_data) begin
                        n_lat <= cfg_n;
                        if (!in_last) begin
                            state <= ST_ACTIVE;
                            busy  <= 1'b1;
                        end else if (next_ptr != 2'd0) begin
                            state <= ST_PAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (accept_data && in_last) begin
                        if (next_ptr == 2'd0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (accept_pad && next_ptr == 2'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STRIPE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stripe_cnt <= '0;
        end else if (stripe_done) begin
            stripe_cnt <= stripe_cnt + 1'b1;
        end
    end
`endif

endmodule
